// File: rtl/ethernet_mac_pkg.sv
// ethernet_mac_pkg: constants and types shared by the RX decapsulator and
// the TX encapsulator of the tri-mode MAC.
//   PREAMBLE_DATA / SFD_DATA : preamble filler byte and start-of-frame byte
//   FCS_LENGTH / HEADER_LENGTH : trailer and header sizes in bytes
//   frame_length()            : payload length -> on-wire frame length (incl. FCS)
//   rx_state_t                : receive state machine states
package ethernet_mac_pkg;

  localparam logic [7:0] PREAMBLE_DATA = 8'h55;
  localparam logic [7:0] SFD_DATA      = 8'hD5;
  localparam int         FCS_LENGTH    = 4;
  localparam int         HEADER_LENGTH = 14;

  // DA + SA + type/length + payload + FCS
  function automatic int frame_length(input int payload_length);
    return payload_length + HEADER_LENGTH + FCS_LENGTH;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    FLUSH,
    DROP
  } rx_state_t;

endpackage

// File: rtl/ethernet_mac_decap_if.sv
// ethernet_mac_decap_if: byte-wide AXI-stream leaving the RX decapsulator.
//   tdata  : frame byte
//   tvalid : one-cycle beat strobe (no back-pressure, sink always accepts)
//   tlast  : final byte before the stripped FCS
//   tuser  : frame status, meaningful only with tlast (1 = bad frame)
// Modports: master (decapsulator side), slave (RX FIFO side).
interface ethernet_mac_decap_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/ethernet_crc32.sv
// ethernet_crc32: byte-serial IEEE 802.3 CRC-32 (reflected, init all-ones).
//   clk, reset : clock, synchronous active-high reset
//   clear      : reload the initial value
//   en         : fold data_in into the running CRC
//   data_in    : byte to fold in, LSB first as on the wire
//   crc_out    : registered FCS value, arranged so crc_out[31:24] is the
//                first FCS byte on the wire and crc_out[7:0] the last
module ethernet_crc32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFLECTED = 32'hEDB88320;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '1;
    end else if (en) begin
      for (int i = 0; i < 8; i++) begin
        crc_d = (crc_d >> 1) ^ ((crc_d[0] ^ data_in[i]) ? POLY_REFLECTED : 32'h0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= '1;
    end else begin
      crc_q <= crc_d;
    end
  end

  // The FCS is the complemented register sent low byte first; byte-swap so
  // the first wire byte lands in the top byte of crc_out.
  assign crc_out = ~{crc_q[7:0], crc_q[15:8], crc_q[23:16], crc_q[31:24]};

endmodule

// File: rtl/ethernet_mac_decap.sv
// ethernet_mac_decap: GMII receive-side frame decapsulation.
// Finds preamble/SFD, streams DA..pad onto a byte AXI-stream, strips the
// FCS and reports CRC / length / rx-error status on tuser with tlast.
//   clk, reset   : rx clock, synchronous active-high reset
//   clk_enable   : byte strobe (every cycle at 1G, 1/10 at 100M, 1/100 at 10M)
//   gmii_rxd/rxdv/rxer : PHY receive byte, data valid, error
//   mac_address  : station address, [47:40] is the first DA byte
//   m_axis       : output stream (ethernet_mac_decap_if.master)
// Build option: ETHERNET_MAC_DECAP_ADDR_FILTER_EN drops frames whose DA is
// neither mac_address nor broadcast before any byte is emitted.
module ethernet_mac_decap
  import ethernet_mac_pkg::*;
#(
  parameter int MIN_PAYLOAD_LENGTH = 46,
  parameter int MAX_PAYLOAD_LENGTH = 1500
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic [7:0]           gmii_rxd,
  input  logic                 gmii_rxdv,
  input  logic                 gmii_rxer,
  input  logic [47:0]          mac_address,
  ethernet_mac_decap_if.master m_axis
);

  localparam int MIN_FRAME_LENGTH = frame_length(MIN_PAYLOAD_LENGTH);
  localparam int MAX_FRAME_LENGTH = frame_length(MAX_PAYLOAD_LENGTH);
  localparam int CW               = $clog2(MAX_FRAME_LENGTH + 2);

  localparam logic [CW-1:0] COUNT_SAT       = CW'(MAX_FRAME_LENGTH + 1);
  localparam logic [CW-1:0] MIN_COUNT       = CW'(MIN_FRAME_LENGTH);
  localparam logic [CW-1:0] MAX_COUNT       = CW'(MAX_FRAME_LENGTH);
  localparam logic [CW-1:0] EMIT_COUNT      = CW'(6);   // DA fully in the delay line
  localparam logic [CW-1:0] CRC_COUNT       = CW'(FCS_LENGTH);
  localparam logic [CW-1:0] MIN_FLUSH_COUNT = CW'(10);  // DA + FCS, anything shorter is noise

`ifdef ETHERNET_MAC_DECAP_ADDR_FILTER_EN
  localparam bit ADDR_FILTER = 1'b1;
`else
  localparam bit ADDR_FILTER = 1'b0;
`endif

  rx_state_t     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    sr_q [6];
  logic [7:0]    sr_d [6];
  logic          err_rx_q, err_rx_d;
  logic          flush_last_q, flush_last_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;

  logic          shift_en;
  logic          crc_en;
  logic [31:0]   crc_out;
  logic [47:0]   da;
  logic          da_accept;
  logic          crc_bad;
  logic          frame_bad;

  // sr[5] holds the oldest byte, so once six bytes are in, sr[5..0] is the DA.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_da
      assign da[47-8*gi -: 8] = sr_q[5-gi];
    end
  endgenerate

  assign da_accept = (da == mac_address) || (da == '1);

  // In FLUSH the delay line holds the received FCS, oldest byte in sr[3].
  assign crc_bad   = {sr_q[3], sr_q[2], sr_q[1], sr_q[0]} != crc_out;
  assign frame_bad = crc_bad | err_rx_q | (count_q < MIN_COUNT) | (count_q > MAX_COUNT);

  // Bytes at least four deep can never be FCS, so the CRC trails the input.
  assign crc_en = shift_en && (count_q >= CRC_COUNT);

  ethernet_crc32 u_crc32 (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .en      (crc_en),
    .data_in (sr_q[3]),
    .crc_out (crc_out)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sr_d         = sr_q;
    err_rx_d     = err_rx_q;
    flush_last_d = flush_last_q;
    tdata_d      = tdata_q;
    tvalid_d     = 1'b0;
    tlast_d      = 1'b0;
    tuser_d      = 1'b0;
    shift_en     = 1'b0;

    if (clk_enable) begin
      case (state_q)
        IDLE, PREAMBLE: begin
          if (!gmii_rxdv) begin
            state_d = IDLE;
          end else if (gmii_rxd == PREAMBLE_DATA) begin
            state_d = PREAMBLE;
          end else if (gmii_rxd == SFD_DATA) begin
            state_d  = DATA;
            count_d  = '0;
            err_rx_d = 1'b0;
          end else begin
            state_d = DROP;
          end
        end

        DATA: begin
          if (gmii_rxdv) begin
            if (ADDR_FILTER && (count_q == EMIT_COUNT) && !da_accept) begin
              state_d = DROP;
            end else begin
              shift_en = 1'b1;
              sr_d[0]  = gmii_rxd;
              for (int i = 1; i < 6; i++) begin
                sr_d[i] = sr_q[i-1];
              end
              if (count_q != COUNT_SAT) begin
                count_d = count_q + 1'b1;
              end
              if (count_q >= EMIT_COUNT) begin
                tvalid_d = 1'b1;
                tdata_d  = sr_q[5];
              end
              if (gmii_rxer) begin
                err_rx_d = 1'b1;
              end
            end
          end else if (count_q < MIN_FLUSH_COUNT) begin
            state_d = IDLE;
          end else begin
            state_d      = FLUSH;
            flush_last_d = 1'b0;
          end
        end

        // Two strobes drain the last two non-FCS bytes from the delay line.
        FLUSH: begin
          tvalid_d = 1'b1;
          if (!flush_last_q) begin
            tdata_d      = sr_q[5];
            flush_last_d = 1'b1;
          end else begin
            tdata_d      = sr_q[4];
            tlast_d      = 1'b1;
            tuser_d      = frame_bad;
            flush_last_d = 1'b0;
            state_d      = IDLE;
          end
        end

        DROP: begin
          if (!gmii_rxdv) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      err_rx_q     <= 1'b0;
      flush_last_q <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      err_rx_q     <= err_rx_d;
      flush_last_q <= flush_last_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      sr_q         <= sr_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;

endmodule

// File: tb/tb_ethernet_mac_decap.sv
// tb_ethernet_mac_decap: table-driven directed frames, hand-written corner
// sequences (preamble abort, bad preamble, mid-frame reset) and randomized
// frames, each checked against a frame-level reference model.
module tb_ethernet_mac_decap;

  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
`ifdef ETHERNET_MAC_DECAP_ADDR_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [7:0]  gmii_rxd;
  logic        gmii_rxdv;
  logic        gmii_rxer;
  logic [47:0] mac_address;

  always #5 clk = ~clk;

  ethernet_mac_decap_if axis ();

  ethernet_mac_decap dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .gmii_rxd    (gmii_rxd),
    .gmii_rxdv   (gmii_rxdv),
    .gmii_rxer   (gmii_rxer),
    .mac_address (mac_address),
    .m_axis      (axis)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int period    = 1;

  // ---------------- output monitor ----------------
  logic [7:0] got_data [$];
  bit         got_last [$];
  bit         got_user [$];
  int         stray_cnt = 0;
  logic       cen_prev  = 1'b0;
  logic       tv_prev   = 1'b0;

  // Beats must follow a strobe cycle, never be back-to-back at reduced speed,
  // and tlast/tuser may only appear where they are meaningful.
  always @(negedge clk) begin
    if (axis.tvalid) begin
      got_data.push_back(axis.tdata);
      got_last.push_back(axis.tlast);
      got_user.push_back(axis.tuser);
    end
    if (!reset && ((axis.tvalid && (!cen_prev || (tv_prev && period > 1) ||
                                    (axis.tuser && !axis.tlast))) ||
                   (!axis.tvalid && (axis.tlast || axis.tuser)))) begin
      stray_cnt <= stray_cnt + 1;
    end
    cen_prev <= clk_enable;
    tv_prev  <= axis.tvalid;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] crc_tab [256];
  logic [7:0]  frame_q [$];
  logic [7:0]  exp_q [$];

  function automatic void build_crc_table();
    for (int b = 0; b < 256; b++) begin
      logic [31:0] c;
      c = 32'(b);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[b] = c;
    end
  endfunction

  // FCS value over frame_q[0..n-1]; transmitted low byte first.
  function automatic logic [31:0] model_fcs(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) c = crc_tab[c[7:0] ^ frame_q[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic make_frame(input int n, input int da_kind, input bit rnd, input bit corrupt);
    logic [47:0] da;
    logic [31:0] fcs;
    int          body;
    case (da_kind)
      1:       da = 48'h02_00_00_00_00_02;
      2:       da = '1;
      3:       da = MAC;
      default: begin
        da[47:32] = 16'($urandom);
        da[31:0]  = $urandom;
      end
    endcase
    body = (n >= 4) ? n - 4 : n;
    frame_q.delete();
    for (int i = 0; i < body; i++) begin
      if (i < 6) frame_q.push_back(da[47-8*i -: 8]);
      else if (rnd) frame_q.push_back(8'($urandom));
      else frame_q.push_back(i[7:0]);
    end
    if (n >= 4) begin
      fcs = model_fcs(body);
      frame_q.push_back(fcs[7:0]);
      frame_q.push_back(fcs[15:8]);
      frame_q.push_back(fcs[23:16]);
      frame_q.push_back(fcs[31:24]);
      if (corrupt) frame_q[n-1] = frame_q[n-1] ^ 8'h01;
    end
  endtask

  // A frame of n wire bytes (FCS included) yields its n-4 non-FCS bytes with
  // tlast on the final one; frames under 10 bytes never complete.
  task automatic model(input int n, input bit had_err, output int nb, output bit lst, output bit usr);
    logic [47:0] da_w;
    bit          accept;
    bit          fcs_ok;
    accept = 1'b1;
    if (FILTER && n >= 7) begin
      da_w   = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
      accept = (da_w == MAC) || (da_w == '1);
    end
    nb = (n >= 10) ? n - 4 : ((n > 6) ? n - 6 : 0);
    if (!accept) nb = 0;
    lst    = accept && (n >= 10);
    fcs_ok = (n >= 10) && ({frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]} == model_fcs(n - 4));
    usr    = lst && (!fcs_ok || had_err || n < 64 || n > 1518);
    exp_q.delete();
    for (int i = 0; i < nb; i++) exp_q.push_back(frame_q[i]);
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic dv, input logic [7:0] d, input logic er);
    gmii_rxdv  = dv;
    gmii_rxd   = d;
    gmii_rxer  = er;
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    if (period > 1) begin
      clk_enable = 1'b0;
      repeat (period - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input int npre, input int err_pos);
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    repeat (npre) tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) tick(1'b1, frame_q[i], 1'(i == err_pos));
    repeat (12) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic compare_frame(input string name, input int base, input int sbase,
                               input int exp_beats, input bit exp_last, input bit exp_user);
    int nb_got;
    int last_cnt;
    int mism;
    nb_got   = got_data.size() - base;
    last_cnt = 0;
    mism     = 0;
    for (int i = base; i < got_data.size(); i++) if (got_last[i]) last_cnt++;
    for (int i = 0; i < nb_got && i < exp_q.size(); i++) if (got_data[base+i] !== exp_q[i]) mism++;
    $display("frame %s: beats=%0d last=%0d tuser=%0d", name, nb_got, last_cnt,
             (nb_got > 0) ? int'(got_user[$]) : 0);
    check({name, " beats"}, nb_got, exp_beats);
    check({name, " tlast count"}, last_cnt, int'(exp_last));
    if (exp_last && nb_got > 0) begin
      check({name, " tlast on final beat"}, got_last[$], 1);
      check({name, " tuser"}, got_user[$], exp_user);
    end
    check({name, " data mismatches"}, mism, 0);
    check({name, " protocol violations"}, stray_cnt - sbase, 0);
  endtask

  task automatic run_frame(input string name, input int n, input int err_pos, input int npre,
                           input int exp_beats, input bit exp_last, input bit exp_user);
    int base;
    int sbase;
    base  = got_data.size();
    sbase = stray_cnt;
    send_frame(npre, err_pos);
    compare_frame(name, base, sbase, exp_beats, exp_last, exp_user);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int len;
    int da_kind;
    bit corrupt;
    int err_pos;
    int per;
    int npre;
    int exp_beats;
    bit exp_last;
    bit exp_user;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int nb;
    bit lst;
    bit usr;
    int base;
    int sbase;

    vecs.push_back('{64,   3, 0, -1,   1, 7, 60,   1, 0});  // good minimum frame
    vecs.push_back('{64,   3, 1, -1,   1, 7, 60,   1, 1});  // last FCS byte flipped
    vecs.push_back('{64,   3, 0, 20,   1, 7, 60,   1, 1});  // rxer mid-frame
    vecs.push_back('{64,   3, 0, 62,   1, 7, 60,   1, 1});  // rxer inside FCS
    vecs.push_back('{40,   3, 0, -1,   1, 7, 36,   1, 1});  // runt, good CRC
    vecs.push_back('{63,   3, 0, -1,   1, 7, 59,   1, 1});  // one byte short
    vecs.push_back('{6,    3, 0, -1,   1, 7, 0,    0, 0});  // too short to emit
    vecs.push_back('{1518, 3, 0, -1,   1, 7, 1514, 1, 0});  // maximum frame
    vecs.push_back('{1519, 3, 0, -1,   1, 7, 1515, 1, 1});  // one byte long
    vecs.push_back('{1600, 3, 0, -1,   1, 7, 1596, 1, 1});  // count saturation
    vecs.push_back('{64,   3, 0, -1,  10, 7, 60,   1, 0});  // 100M
    vecs.push_back('{64,   3, 0, -1, 100, 7, 60,   1, 0});  // 10M
    vecs.push_back('{64,   3, 0, -1,   1, 0, 60,   1, 0});  // SFD without preamble
    vecs.push_back('{64,   1, 0, -1,   1, 7, FILTER ? 0 : 60, !FILTER, 0});  // foreign DA
    vecs.push_back('{64,   2, 0, -1,   1, 7, 60,   1, 0});  // broadcast DA
    vecs.push_back('{64,   3, 0, -1,   2, 7, 60,   1, 0});  // own DA, half-rate strobe

    build_crc_table();
    mac_address = MAC;
    reset       = 1'b1;
    clk_enable  = 1'b1;
    gmii_rxdv   = 1'b1;
    gmii_rxd    = 8'hD5;
    gmii_rxer   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset tdata", axis.tdata, 0);
    check("reset tvalid", axis.tvalid, 0);
    check("reset tlast", axis.tlast, 0);
    check("reset tuser", axis.tuser, 0);
    reset     = 1'b0;
    gmii_rxdv = 1'b0;
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    check("idle tvalid", axis.tvalid, 0);

    foreach (vecs[v]) begin
      period = vecs[v].per;
      make_frame(vecs[v].len, vecs[v].da_kind, 1'b0, vecs[v].corrupt);
      model(vecs[v].len, vecs[v].err_pos >= 0, nb, lst, usr);
      run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].err_pos, vecs[v].npre,
                vecs[v].exp_beats, vecs[v].exp_last, vecs[v].exp_user);
    end
    period = 1;

    // Preamble then rxdv falls before any SFD.
    base  = got_data.size();
    sbase = stray_cnt;
    exp_q.delete();
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    repeat (7) tick(1'b1, 8'h55, 1'b0);
    repeat (12) tick(1'b0, 8'h00, 1'b0);
    compare_frame("preamble_abort", base, sbase, 0, 1'b0, 1'b0);

    // Garbage inside the preamble drops the whole burst.
    make_frame(64, 3, 1'b0, 1'b0);
    base  = got_data.size();
    sbase = stray_cnt;
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'hAA, 1'b0);
    tick(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) tick(1'b1, frame_q[i], 1'b0);
    repeat (12) tick(1'b0, 8'h00, 1'b0);
    exp_q.delete();
    compare_frame("bad_preamble", base, sbase, 0, 1'b0, 1'b0);

    // Reset at byte 30: the 24 beats already out stay, no tlast follows.
    make_frame(64, 3, 1'b0, 1'b0);
    model(64, 1'b0, nb, lst, usr);
    exp_q = exp_q[0:23];
    base  = got_data.size();
    sbase = stray_cnt;
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    repeat (7) tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b1, frame_q[i], 1'b0);
    reset    = 1'b1;
    gmii_rxd = frame_q[30];
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset tvalid", axis.tvalid, 0);
    check("midreset tlast", axis.tlast, 0);
    for (int i = 31; i < 64; i++) tick(1'b1, frame_q[i], 1'b0);
    repeat (12) tick(1'b0, 8'h00, 1'b0);
    compare_frame("reset_mid_frame", base, sbase, 24, 1'b0, 1'b0);

    make_frame(64, 3, 1'b0, 1'b0);
    model(64, 1'b0, nb, lst, usr);
    run_frame("after_reset", 64, -1, 7, 60, 1'b1, 1'b0);

    // Randomized frames against the model.
    for (int r = 0; r < 30; r++) begin
      int n;
      int dk;
      int ep;
      bit cor;
      int pers [4];
      pers = '{1, 1, 2, 5};
      n    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1519, 1530)) : int'($urandom_range(10, 140));
      dk   = $urandom_range(1, 4);
      cor  = ($urandom_range(0, 3) == 0);
      ep   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      period = pers[$urandom_range(0, 3)];
      make_frame(n, dk, 1'b1, cor);
      model(n, ep >= 0, nb, lst, usr);
      run_frame($sformatf("rand%0d_len%0d", r, n), n, ep, $urandom_range(0, 7), nb, lst, usr);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
